// File: rtl/escritor_tabuleiro.sv
// Write side of the board state: stores moves in the 81-cell micro array,
// scans the affected micro board for a result and updates the macro RAM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for zera (new game) or inicia (move)
// LIMPA    | clearing board k and macro RAM entry k, k = 0..8
// VALIDA   | checking one-hot inputs, macro board and target cell
// GRAVA    | writing the player's mark into the target cell
// VERIFICA | scanning winning line l = 0..7 of the affected board
// ESCREVE  | macro RAM write cycle (we_macro high only if board decided)
// FIM      | pronto pulse, back to IDLE
module escritor_tabuleiro (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera,
    input  logic       inicia,
    input  logic       jogador,
    input  logic [8:0] macro_onehot,
    input  logic [8:0] micro_onehot,
    output logic       ocupado,
    output logic       pronto,
    output logic       jogada_invalida,
    output logic [1:0] resultado,
    output logic       we_macro,
    output logic [3:0] addr_macro,
    output logic [1:0] data_macro
);

    typedef enum logic [2:0] {
        IDLE, LIMPA, VALIDA, GRAVA, VERIFICA, ESCREVE, FIM
    } estado_t;

    estado_t    estado;
    logic [3:0] k;
    logic [2:0] l;
    logic [3:0] m_idx;
    logic [3:0] c_idx;
    logic       m_ok;
    logic       c_ok;
    logic       jog_q;
    logic [1:0] vencedor;
    logic [1:0] cel [81];
    logic [1:0] macro_est [9];

    // {valid, index}; valid only when exactly one bit is set
    function automatic logic [4:0] decodifica(input logic [8:0] oh);
        logic [3:0] idx;
        logic [3:0] n;
        idx = 4'd0;
        n   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (oh[i]) begin
                idx = 4'(i);
                n   = n + 4'd1;
            end
        end
        return {(n == 4'd1), idx};
    endfunction

    function automatic logic [11:0] linha(input logic [2:0] sel);
        case (sel)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    logic [6:0]  base;
    logic [6:0]  kbase;
    logic [11:0] pos;
    logic [1:0]  ca, cb, cc;
    logic        linha_vence;
    logic        cheio;
    logic [1:0]  res_final;
    logic [1:0]  cel_alvo;

    assign base     = {m_idx, 3'b000} + {3'b000, m_idx};
    assign kbase    = {k, 3'b000} + {3'b000, k};
    assign pos      = linha(l);
    assign ca       = cel[base + 7'(pos[11:8])];
    assign cb       = cel[base + 7'(pos[7:4])];
    assign cc       = cel[base + 7'(pos[3:0])];
    assign cel_alvo = cel[base + 7'(c_idx)];

    assign linha_vence = (ca != 2'b00) && (ca == cb) && (cb == cc);

    always_comb begin
        cheio = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (cel[base + 7'(i)] == 2'b00) cheio = 1'b0;
        end
    end

    // The last line is checked in the same cycle the result is committed.
    always_comb begin
        res_final = 2'b00;
        if (vencedor != 2'b00)  res_final = vencedor;
        else if (linha_vence)   res_final = ca;
        else if (cheio)         res_final = 2'b11;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= IDLE;
            k               <= 4'd0;
            l               <= 3'd0;
            m_idx           <= 4'd0;
            c_idx           <= 4'd0;
            m_ok            <= 1'b0;
            c_ok            <= 1'b0;
            jog_q           <= 1'b0;
            vencedor        <= 2'b00;
            ocupado         <= 1'b0;
            pronto          <= 1'b0;
            jogada_invalida <= 1'b0;
            resultado       <= 2'b00;
            we_macro        <= 1'b0;
            addr_macro      <= 4'd0;
            data_macro      <= 2'b00;
            for (int i = 0; i < 81; i++) cel[i] <= 2'b00;
            for (int i = 0; i < 9; i++) macro_est[i] <= 2'b00;
        end else begin
            pronto <= 1'b0;
            case (estado)
                IDLE: begin
                    if (zera) begin
                        estado     <= LIMPA;
                        ocupado    <= 1'b1;
                        k          <= 4'd0;
                        we_macro   <= 1'b1;
                        addr_macro <= 4'd0;
                        data_macro <= 2'b00;
                    end else if (inicia) begin
                        estado         <= VALIDA;
                        ocupado        <= 1'b1;
                        {m_ok, m_idx}  <= decodifica(macro_onehot);
                        {c_ok, c_idx}  <= decodifica(micro_onehot);
                        jog_q          <= jogador;
                    end
                end
                LIMPA: begin
                    macro_est[k] <= 2'b00;
                    for (int i = 0; i < 9; i++) cel[kbase + 7'(i)] <= 2'b00;
                    if (k == 4'd8) begin
                        we_macro        <= 1'b0;
                        addr_macro      <= 4'd0;
                        estado          <= FIM;
                        pronto          <= 1'b1;
                        jogada_invalida <= 1'b0;
                        resultado       <= 2'b00;
                    end else begin
                        k          <= k + 4'd1;
                        addr_macro <= k + 4'd1;
                    end
                end
                VALIDA: begin
                    if (!m_ok || !c_ok || macro_est[m_idx] != 2'b00 ||
                        cel_alvo != 2'b00) begin
                        estado          <= FIM;
                        pronto          <= 1'b1;
                        jogada_invalida <= 1'b1;
                    end else begin
                        estado <= GRAVA;
                    end
                end
                GRAVA: begin
                    cel[base + 7'(c_idx)] <= jog_q ? 2'b10 : 2'b01;
                    l        <= 3'd0;
                    vencedor <= 2'b00;
                    estado   <= VERIFICA;
                end
                VERIFICA: begin
                    if (vencedor == 2'b00 && linha_vence) vencedor <= ca;
                    if (l == 3'd7) begin
                        resultado <= res_final;
                        if (res_final != 2'b00) begin
                            we_macro         <= 1'b1;
                            addr_macro       <= m_idx;
                            data_macro       <= res_final;
                            macro_est[m_idx] <= res_final;
                        end
                        estado <= ESCREVE;
                    end else begin
                        l <= l + 3'd1;
                    end
                end
                ESCREVE: begin
                    we_macro        <= 1'b0;
                    addr_macro      <= 4'd0;
                    data_macro      <= 2'b00;
                    estado          <= FIM;
                    pronto          <= 1'b1;
                    jogada_invalida <= 1'b0;
                end
                FIM: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/escritor_tabuleiro.md
# escritor_tabuleiro

Write-side companion to the board-state read path in the datapath. It accepts a validated move (macro board, micro cell, player) and stores the mark in an internal 81-cell micro board array. It then scans the 8 winning lines of the affected micro board and, when that board is decided, writes its result into the 9-entry macro board-state RAM (`ram_board_state` write port). It also performs the new-game clear of both the micro array and the macro RAM.

## Interface

Parameters: none. Board geometry is fixed at 9×9.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `zera` in 1: new-game request; sampled only in IDLE.
- `inicia` in 1: move request; sampled only in IDLE.
- `jogador` in 1: 0 = X (code 01), 1 = O (code 10); captured together with `inicia`.
- `macro_onehot` in 9: target micro board, one-hot (bit i selects board i).
- `micro_onehot` in 9: target cell inside that board, one-hot.
- `ocupado` out 1: high in every state other than IDLE.
- `pronto` out 1: one-cycle completion pulse.
- `jogada_invalida` out 1: valid only while `pronto`=1; 1 means the move was rejected and nothing was written.
- `resultado` out 2: result of the last evaluated board (00 open, 01 X won, 10 O won, 11 draw); held until the next evaluation or clear.
- `we_macro` out 1: write enable for the macro RAM.
- `addr_macro` out 4: macro RAM address, 0..8.
- `data_macro` out 2: macro RAM write data.

## Operation

- Storage:
  - `cel[0..80]` is a 2-bit array indexed macro*9+micro.
  - `macro_est[0..8]` is a 2-bit shadow copy of the macro RAM.
- One-hot decode: index = position of the single set bit. Zero bits set, or more than one bit set, is invalid.

FSM states:
- IDLE
  - `zera`=1 → LIMPA. `zera` has priority over `inicia`.
  - otherwise `inicia`=1 → VALIDA. Captures the decoded indices and `jogador`.
- LIMPA (9 cycles, counter k=0..8)
  - `we_macro`=1, `addr_macro`=k, `data_macro`=00.
  - `macro_est[k]`←00 and the 9 cells of board k ←00.
  - After k=8 → FIM with `jogada_invalida`=0, `resultado`←00.
- VALIDA (1 cycle). The move is invalid if any of:
  - either one-hot input is invalid;
  - `macro_est[macro]`≠00;
  - the target cell ≠00.
  - Invalid → FIM with `jogada_invalida`=1. Otherwise → GRAVA.
- GRAVA (1 cycle): target cell ← 01 or 10 according to `jogador`.
- VERIFICA (8 cycles, line counter l=0..7)
  - Line order: {0,1,2} {3,4,5} {6,7,8} {0,3,6} {1,4,7} {2,5,8} {0,4,8} {2,4,6}.
  - A line wins when its three cells are equal and nonzero. The first winning line latches the winner code.
  - All 8 lines are always scanned, so latency is fixed.
- ESCREVE (1 cycle)
  - Result = winner if any; else 11 if all 9 cells are nonzero; else 00.
  - `resultado`←result.
  - If result≠00: `we_macro`=1, `addr_macro`=macro, `data_macro`=result, and `macro_est[macro]`←result.
- FIM (1 cycle): `pronto`=1 → IDLE.

Rules:
- `inicia` and `zera` are ignored while `ocupado`=1; they are not queued.
- `we_macro` is high only in LIMPA and in the ESCREVE case above. `addr_macro`/`data_macro` are 0 whenever `we_macro`=0.

## Timing

- Reset values:
  - state IDLE, all `cel` and `macro_est` = 00;
  - `ocupado`=0, `pronto`=0, `jogada_invalida`=0, `resultado`=00, `we_macro`=0, `addr_macro`=0, `data_macro`=00.
  - Reset does not write the macro RAM; the controller issues `zera` after reset.
- Let edge E be the edge that samples `inicia`=1 in IDLE. Each bullet gives the edge at which the signal is sampled:
  - Valid move: cell written at E+2; ESCREVE write at E+11; `pronto` high at E+12; IDLE at E+13.
  - Invalid move: `pronto`=1 and `jogada_invalida`=1 at E+2; no cell or RAM write.
- Clear: `we_macro` high for 9 consecutive cycles sampled at E+1..E+9 (addresses 0..8); `pronto` at E+10.
- Asynchronous reset mid-operation:
  - aborts immediately and forces the reset values;
  - macro RAM writes already issued are not undone.

## Test plan

1. Reset, then `zera`: we_macro=1 for 9 cycles with addr 0,1,…,8 and data 00; `pronto` at E+10 with `jogada_invalida`=0.
2. X plays board 4 cells 0, 4, 8, with O moves elsewhere in between. On the third X move: `we_macro` at E+11, addr 4, data 01, `resultado`=01, `pronto` at E+12.
3. Repeat the cell-0 move on board 4 after it is won, and a move on an occupied cell of another board: `pronto` at E+2, `jogada_invalida`=1, no `we_macro`.
4. `micro_onehot`=9'b000000011 and `macro_onehot`=0: both rejected with `jogada_invalida`=1, no cell change.
5. Fill board 0 with a 9-move draw pattern (X O X / X O O / O X X): the last move gives `resultado`=11, write addr 0 data 11. A non-final move gives `resultado`=00 and no `we_macro`.
6. `inicia` and `zera` high together in IDLE → clear sequence runs. Pulse `reset` low at E+5 of a move: all outputs drop to reset values immediately; a subsequent `zera` and move complete normally.
